// File: rtl/uart_tx.sv
// uart_tx -- serial UART transmitter, 8 data bits, no parity, 1 or 2 stop bits,
// LSB first. A producer hands over one byte per valid/ready handshake. The
// transmitter then drives the idle-high serial line for one full frame.
//
// Ports
//   clk            in   1  clock
//   rst            in   1  asynchronous reset, active-high
//   tx_data        in   8  byte to send, sampled only on the handshake edge
//   tx_data_valid  in   1  producer has a byte
//   tx_data_ready  out  1  transmitter can accept a byte (registered)
//   tx_busy        out  1  frame in progress (START..STOP)
//   tx_pin         out  1  serial output, idle high (registered)
module uart_tx #(
   parameter int CLK_FRE   = 50,      // MHz
   parameter int BAUD_RATE = 115200,
   parameter int STOP_BITS = 1        // 2 selects two stop bits, anything else one
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_data_ready,
   output logic       tx_busy,
   output logic       tx_pin
);

   localparam int          CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
   localparam logic [15:0] CYC_LAST = 16'(CYCLE - 1);
   // index of the final stop bit; the stop-bit index counts whole bit periods
   // so cycle_cnt never has to reach 2*CYCLE
   localparam logic        STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]  state;
   logic [15:0] cycle_cnt;
   logic [2:0]  bit_cnt;
   logic        stop_idx;
   logic [7:0]  tx_reg;
   logic [2:0]  next_bit;
   logic        bit_end;

   assign next_bit = bit_cnt + 3'd1;
   assign bit_end  = (cycle_cnt == CYC_LAST);

   // tx_pin is always loaded with the value for the *next* cycle. A state
   // change therefore shows on the line in the same cycle as the new state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         cycle_cnt     <= '0;
         bit_cnt       <= '0;
         stop_idx      <= 1'b0;
         tx_reg        <= '0;
         tx_pin        <= 1'b1;
         tx_data_ready <= 1'b1;
         tx_busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               cycle_cnt     <= '0;
               bit_cnt       <= '0;
               stop_idx      <= 1'b0;
               tx_pin        <= 1'b1;
               tx_data_ready <= 1'b1;
               tx_busy       <= 1'b0;
               if (tx_data_valid && tx_data_ready) begin
                  tx_reg        <= tx_data;
                  state         <= S_START;
                  tx_data_ready <= 1'b0;
                  tx_busy       <= 1'b1;
                  tx_pin        <= 1'b0;   // start bit begins next cycle
               end
            end
            S_START: begin
               if (bit_end) begin
                  state     <= S_SEND;
                  cycle_cnt <= '0;
                  bit_cnt   <= '0;
                  tx_pin    <= tx_reg[0];
               end else begin
                  cycle_cnt <= cycle_cnt + 16'd1;
               end
            end
            S_SEND: begin
               if (bit_end) begin
                  cycle_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     state   <= S_STOP;
                     bit_cnt <= '0;
                     tx_pin  <= 1'b1;
                  end else begin
                     bit_cnt <= next_bit;
                     tx_pin  <= tx_reg[next_bit];
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + 16'd1;
               end
            end
            S_STOP: begin
               tx_pin <= 1'b1;
               if (bit_end) begin
                  cycle_cnt <= '0;
                  if (stop_idx == STOP_LAST) begin
                     state         <= S_IDLE;
                     stop_idx      <= 1'b0;
                     tx_data_ready <= 1'b1;
                     tx_busy       <= 1'b0;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + 16'd1;
               end
            end
            default: begin
               state         <= S_IDLE;
               cycle_cnt     <= '0;
               bit_cnt       <= '0;
               stop_idx      <= 1'b0;
               tx_pin        <= 1'b1;
               tx_data_ready <= 1'b1;
               tx_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
